pipelined_datapath: RTL and testbench
=====================================

# pipelined_datapath

Parametrised three-stage (ID / EX / MEM-WB) successor to the single-cycle MIPS datapath. It takes the same decoded control signals and 32-bit instruction word, adds operand forwarding so back-to-back dependent instructions need no stalls, and reports writebacks and a retired-instruction count. It sits between the instruction fetch unit, which consumes `Zero` and `seOut`, and the control decoder.

## Interface
- `WIDTH`, 32: datapath width; must be ≥ 16.
- `NREG`, 32: number of architectural registers; must be ≤ 32. `$0` is hardwired to zero.
- `DMEM_DEPTH`, 64: data memory depth in words; must be a power of 2. `AW = log2(DMEM_DEPTH)`.
- `clk` in 1: single clock; everything is rising-edge.
- `rst_n` in 1: synchronous, active-low reset.
- `in_valid` in 1: issue the current instruction and control at this edge.
- `Instructions` in 32: Rs=[25:21], Rt=[20:16], Rd=[15:11], Imm=[15:0]; [31:26] ignored.
- `RegDst`, `RegWr`, `ALUsrc`, `MemWr`, `MemToReg` in 1 each: decoded control, same meaning as in the single-cycle datapath.
- `ALUcntrl` in 2: 00 add, 01 sub, 10 and, 11 or.
- `seOut` out WIDTH: combinational sign extension of `Imm` to WIDTH.
- `reg_Da` out WIDTH: combinational Rs read at issue, with bypass applied.
- `Zero` out 1: 1 when the MEM-stage ALU result is 0 and the MEM stage is valid.
- `wb_valid` out 1: the MEM-stage instruction writes a register at the next edge.
- `wb_addr` out 5: destination register of the MEM-stage instruction.
- `wb_data` out WIDTH: writeback value of the MEM-stage instruction.
- `retired` out 32: count of valid instructions leaving MEM; wraps modulo 2^32.

## Operation
- **Issue (ID)**, at an edge with `in_valid`=1:
  - Capture Rs/Rt operands, `seOut`, dest and control into the EX latch.
  - dest = `RegDst` ? Rd : Rt.
  - Operand read bypass: if `wb_valid`, `wb_addr`==src and src≠0, use `wb_data`.
  - `in_valid`=0 issues a bubble: EX valid=0 and all controls inert.
- **EX stage:**
  - Operand forward: if MEM is valid, MEM `RegWr`=1, MEM dest==src and src≠0, use MEM `wb_data` (combinational, load data included).
  - Forwarding applies to both Rs and the Rt store data. It takes priority over the captured value.
  - B = `ALUsrc` ? seOut : Rt.
  - ALU result wraps modulo 2^WIDTH; sub is A−B in two's complement.
  - Result, store data, dest and control are captured into the MEM latch at the next edge.
- **MEM/WB stage:**
  - Word address = alu_result[AW+1:2]. Upper bits and bits [1:0] are ignored, so addresses wrap.
  - Load data is an asynchronous array read.
  - `wb_data` = `MemToReg` ? mem[addr] : alu_result.
  - At the edge ending MEM: store writes if `MemWr`; register write if `RegWr`.
  - `wb_valid` = MEM valid & `RegWr` & dest≠0 & dest<NREG.
- **Register indices ≥ NREG:** reads return 0; writes are dropped.
- **`$0`:** writes to it are dropped. It never forwards and never raises `wb_valid`.
- **`retired`:** increments at every edge where the MEM stage is valid, whether or not the instruction writes a register.
- **Stalls:** none. Every dependency distance (1, 2, ≥3) is resolved by forwarding or bypass.

## Timing
- Instruction issued at edge E0:
  - In EX during cycle E0→E1.
  - In MEM during E1→E2, where `wb_*`, `Zero` and the load value are visible.
  - Register file and memory are written at E2.
  - Issue-to-write latency is 2 cycles; throughput is 1 instruction per cycle.
- Dependency at distance 1 (issued at E1): resolved by EX forward. Distance 2 (issued at E2): resolved by issue bypass. Distance ≥3: read from the register file.
- A store at distance 1 before a load to the same address (store in MEM while the load is in EX): the load reads the new data in its own MEM cycle.
- Reset, at any edge with `rst_n`=0:
  - EX and MEM valid cleared; all registers cleared to 0; `retired`=0.
  - Outputs: `Zero`=0, `wb_valid`=0, `wb_addr`=0, `wb_data`=0.
  - In-flight instructions are discarded with no register or memory write at that edge.
  - Data memory contents are not reset.
- `rst_n`=0 together with `in_valid`=1: the instruction is not issued.
- `seOut` and `reg_Da` are combinational from the inputs and current state; they have no reset value.

## Test plan
- Back-to-back dependent ALU ops: issue `addi $1,$0,2015`, `addi $2,$0,404`, `add $1,$1,$2` on consecutive edges -> `wb_data`=2015, 404, 2419 in consecutive cycles; `$1`=2419 afterwards.
- Store and load: issue `sw $2,0($0)`, then `lw $3,0($0)`, then `add $4,$3,$3` -> loaded `wb_data`=404, then 808 via EX forward; mem[0]=404.
- Zero and sub: `sub $5,$1,$1` -> `Zero`=1 in its MEM cycle. `sub $5,$1,$2` -> `Zero`=0 and `wb_data`=2015.
- Sign extension and width: `addi $6,$0,0xFFFF` -> 0xFFFFFFFF at WIDTH=32; rerun with WIDTH=16 -> 0xFFFF. `addi` of 0x7FFF to 0xFFFF8001 wraps to 0.
- `$0` and out-of-range registers:
  - `addi $0,$0,5` -> `wb_valid`=0, `$0` reads 0.
  - With NREG=8, a write to `$9` is dropped and a read of `$9` returns 0.
  - `sw` to address 4·DMEM_DEPTH aliases mem[0].
- Reset mid-flight: two instructions in EX/MEM, pull `rst_n` low for 1 edge -> no write occurs; `wb_valid`=0, `Zero`=0, `retired`=0; all registers read 0.
- Bubbles: alternate `in_valid`=1/0 over 6 edges -> `retired`=3; `wb_valid` pulses 3 times.

Source files
------------

// File: rtl/pipelined_datapath.sv
// ---------------------------------------------------------------------------
// pipelined_datapath
//
// Three-stage (ID / EX / MEM-WB) MIPS-style datapath. It takes decoded control
// and the 32-bit instruction word, forwards operands so that dependent
// instructions at any distance never stall, and reports each writeback and a
// count of retired instructions.
//
// Ports
//   clk, rst_n         : single rising-edge clock, synchronous active-low reset
//   in_valid           : issue Instructions + control at this edge
//   Instructions[31:0] : Rs=[25:21] Rt=[20:16] Rd=[15:11] Imm=[15:0]
//   RegDst, RegWr, ALUsrc, MemWr, MemToReg : decoded control
//   ALUcntrl[1:0]      : 00 add, 01 sub, 10 and, 11 or
//   seOut              : sign-extended Imm (combinational)
//   reg_Da             : Rs operand as it would be captured at issue
//   Zero               : MEM-stage ALU result is zero and MEM is valid
//   wb_valid/addr/data : register write performed at the end of MEM
//   retired            : valid instructions that have left MEM (mod 2^32)
//
// Handshake: in_valid has no ready partner. The pipeline never stalls, so
// every edge with in_valid=1 (and rst_n=1) accepts exactly one instruction;
// in_valid=0 inserts a bubble whose controls are all inert.
// ---------------------------------------------------------------------------
module pipelined_datapath #(
    parameter int WIDTH      = 32,
    parameter int NREG       = 32,
    parameter int DMEM_DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [31:0]      Instructions,
    input  logic             RegDst,
    input  logic             RegWr,
    input  logic             ALUsrc,
    input  logic             MemWr,
    input  logic             MemToReg,
    input  logic [1:0]       ALUcntrl,
    output logic [WIDTH-1:0] seOut,
    output logic [WIDTH-1:0] reg_Da,
    output logic             Zero,
    output logic             wb_valid,
    output logic [4:0]       wb_addr,
    output logic [WIDTH-1:0] wb_data,
    output logic [31:0]      retired
);

    localparam int         AW     = $clog2(DMEM_DEPTH);
    localparam logic [5:0] NREG_L = 6'(NREG);

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    // A register index is live when it is neither $0 nor beyond NREG.
    // Dead indices read as zero, never get written and never forward.
    function automatic logic f_live(input logic [4:0] idx);
        return (idx != 5'd0) && ({1'b0, idx} < NREG_L);
    endfunction

    // -----------------------------------------------------------------------
    // Architectural state
    // -----------------------------------------------------------------------
    // The file is sized for all 32 encodable indices; entries at or above
    // NREG are never written and stay at their reset value of zero.
    logic [WIDTH-1:0] r_regs [32];
    logic [WIDTH-1:0] r_dmem [DMEM_DEPTH];
    logic [31:0]      r_retired;

    // -----------------------------------------------------------------------
    // ID: decode fields, register read and issue bypass
    // -----------------------------------------------------------------------
    logic [4:0]       w_rs;
    logic [4:0]       w_rt;
    logic [4:0]       w_rd;
    logic [15:0]      w_imm;
    logic [4:0]       w_dest;
    logic [WIDTH-1:0] w_rf_rs;
    logic [WIDTH-1:0] w_rf_rt;
    logic [WIDTH-1:0] w_id_rs_val;
    logic [WIDTH-1:0] w_id_rt_val;
    logic             w_unused;

    assign w_rs     = Instructions[25:21];
    assign w_rt     = Instructions[20:16];
    assign w_rd     = Instructions[15:11];
    assign w_imm    = Instructions[15:0];
    assign w_dest   = RegDst ? w_rd : w_rt;
    assign w_unused = &{1'b0, Instructions[31:26]};

    assign seOut    = WIDTH'($signed(w_imm));

    assign w_rf_rs  = f_live(w_rs) ? r_regs[w_rs] : '0;
    assign w_rf_rt  = f_live(w_rt) ? r_regs[w_rt] : '0;

    // Distance-2 producer sits in MEM and writes the file at this very edge,
    // so its value is taken from the writeback bus instead. wb_valid already
    // excludes $0 and dead indices, so a plain address match is enough.
    assign w_id_rs_val = (wb_valid && (wb_addr == w_rs)) ? wb_data : w_rf_rs;
    assign w_id_rt_val = (wb_valid && (wb_addr == w_rt)) ? wb_data : w_rf_rt;

    assign reg_Da = w_id_rs_val;

    // -----------------------------------------------------------------------
    // ID/EX latch
    // -----------------------------------------------------------------------
    logic             r_ex_valid;
    logic [4:0]       r_ex_rs;
    logic [4:0]       r_ex_rt;
    logic [4:0]       r_ex_dest;
    logic [WIDTH-1:0] r_ex_rs_val;
    logic [WIDTH-1:0] r_ex_rt_val;
    logic [WIDTH-1:0] r_ex_imm;
    logic             r_ex_regwr;
    logic             r_ex_alusrc;
    logic             r_ex_memwr;
    logic             r_ex_memtoreg;
    logic [1:0]       r_ex_aluc;

    // -----------------------------------------------------------------------
    // EX/MEM latch
    // -----------------------------------------------------------------------
    logic             r_mem_valid;
    logic [4:0]       r_mem_dest;
    logic [WIDTH-1:0] r_mem_result;
    logic [WIDTH-1:0] r_mem_st_data;
    logic             r_mem_regwr;
    logic             r_mem_memwr;
    logic             r_mem_memtoreg;

    // -----------------------------------------------------------------------
    // EX: forwarding and ALU
    // -----------------------------------------------------------------------
    logic             w_fwd_rs;
    logic             w_fwd_rt;
    logic [WIDTH-1:0] w_ex_a;
    logic [WIDTH-1:0] w_ex_st_data;
    logic [WIDTH-1:0] w_ex_b;
    logic [WIDTH-1:0] w_ex_result;

    // Distance-1 producer is in MEM now. wb_data already carries the load
    // value for loads, so load-use needs no stall either.
    assign w_fwd_rs     = wb_valid && (wb_addr == r_ex_rs);
    assign w_fwd_rt     = wb_valid && (wb_addr == r_ex_rt);
    assign w_ex_a       = w_fwd_rs ? wb_data : r_ex_rs_val;
    assign w_ex_st_data = w_fwd_rt ? wb_data : r_ex_rt_val;
    assign w_ex_b       = r_ex_alusrc ? r_ex_imm : w_ex_st_data;

    always_comb begin
        w_ex_result = '0;
        case (r_ex_aluc)
            ALU_ADD: w_ex_result = w_ex_a + w_ex_b;
            ALU_SUB: w_ex_result = w_ex_a - w_ex_b;
            ALU_AND: w_ex_result = w_ex_a & w_ex_b;
            ALU_OR:  w_ex_result = w_ex_a | w_ex_b;
            default: w_ex_result = '0;
        endcase
    end

    // -----------------------------------------------------------------------
    // MEM/WB: asynchronous data memory read and writeback select
    // -----------------------------------------------------------------------
    logic [AW-1:0]    w_mem_addr;
    logic [WIDTH-1:0] w_load_data;

    // Word addressing: byte-offset bits and everything above the array
    // depth are dropped, so addresses alias modulo 4*DMEM_DEPTH.
    assign w_mem_addr  = r_mem_result[AW+1:2];
    assign w_load_data = r_dmem[w_mem_addr];

    assign wb_data  = r_mem_memtoreg ? w_load_data : r_mem_result;
    assign wb_addr  = r_mem_dest;
    assign wb_valid = r_mem_valid && r_mem_regwr && f_live(r_mem_dest);
    assign Zero     = r_mem_valid && (r_mem_result == '0);
    assign retired  = r_retired;

    // -----------------------------------------------------------------------
    // Pipeline latches and retire counter
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ex_valid     <= 1'b0;
            r_ex_rs        <= '0;
            r_ex_rt        <= '0;
            r_ex_dest      <= '0;
            r_ex_rs_val    <= '0;
            r_ex_rt_val    <= '0;
            r_ex_imm       <= '0;
            r_ex_regwr     <= 1'b0;
            r_ex_alusrc    <= 1'b0;
            r_ex_memwr     <= 1'b0;
            r_ex_memtoreg  <= 1'b0;
            r_ex_aluc      <= ALU_ADD;
            r_mem_valid    <= 1'b0;
            r_mem_dest     <= '0;
            r_mem_result   <= '0;
            r_mem_st_data  <= '0;
            r_mem_regwr    <= 1'b0;
            r_mem_memwr    <= 1'b0;
            r_mem_memtoreg <= 1'b0;
            r_retired      <= '0;
        end else begin
            // ID -> EX. A bubble loads an all-zero, inert slot.
            if (in_valid) begin
                r_ex_valid    <= 1'b1;
                r_ex_rs       <= w_rs;
                r_ex_rt       <= w_rt;
                r_ex_dest     <= w_dest;
                r_ex_rs_val   <= w_id_rs_val;
                r_ex_rt_val   <= w_id_rt_val;
                r_ex_imm      <= seOut;
                r_ex_regwr    <= RegWr;
                r_ex_alusrc   <= ALUsrc;
                r_ex_memwr    <= MemWr;
                r_ex_memtoreg <= MemToReg;
                r_ex_aluc     <= ALUcntrl;
            end else begin
                r_ex_valid    <= 1'b0;
                r_ex_rs       <= '0;
                r_ex_rt       <= '0;
                r_ex_dest     <= '0;
                r_ex_rs_val   <= '0;
                r_ex_rt_val   <= '0;
                r_ex_imm      <= '0;
                r_ex_regwr    <= 1'b0;
                r_ex_alusrc   <= 1'b0;
                r_ex_memwr    <= 1'b0;
                r_ex_memtoreg <= 1'b0;
                r_ex_aluc     <= ALU_ADD;
            end

            // EX -> MEM. Bubbles stay zeroed so wb_data/Zero read 0 for them.
            if (r_ex_valid) begin
                r_mem_valid    <= 1'b1;
                r_mem_dest     <= r_ex_dest;
                r_mem_result   <= w_ex_result;
                r_mem_st_data  <= w_ex_st_data;
                r_mem_regwr    <= r_ex_regwr;
                r_mem_memwr    <= r_ex_memwr;
                r_mem_memtoreg <= r_ex_memtoreg;
            end else begin
                r_mem_valid    <= 1'b0;
                r_mem_dest     <= '0;
                r_mem_result   <= '0;
                r_mem_st_data  <= '0;
                r_mem_regwr    <= 1'b0;
                r_mem_memwr    <= 1'b0;
                r_mem_memtoreg <= 1'b0;
            end

            if (r_mem_valid) begin
                r_retired <= r_retired + 32'd1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Register file write (end of MEM). Reset clears every entry and drops
    // the in-flight write.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_regs <= '{default: '0};
        end else if (wb_valid) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    // -----------------------------------------------------------------------
    // Data memory write (end of MEM). Contents survive reset, but a store
    // that is in flight when reset is asserted is discarded.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n && r_mem_valid && r_mem_memwr) begin
            r_dmem[w_mem_addr] <= r_mem_st_data;
        end
    end

endmodule

// File: tb/tb_pipelined_datapath.sv
module tb_pipelined_datapath;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid;
    logic [31:0] instr;
    logic        regdst, regwr, alusrc, memwr, memtoreg;
    logic [1:0]  aluc;

    // Default-parameter instance
    logic [31:0] seOut0, reg_Da0, wb_data0, retired0;
    logic        Zero0, wb_valid0;
    logic [4:0]  wb_addr0;

    // Narrow instance: WIDTH=16, NREG=8, DMEM_DEPTH=16, same stimulus
    logic [15:0] seOut1, reg_Da1, wb_data1;
    logic [31:0] retired1;
    logic        Zero1, wb_valid1;
    logic [4:0]  wb_addr1;

    pipelined_datapath dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .Instructions(instr),
        .RegDst(regdst), .RegWr(regwr), .ALUsrc(alusrc), .MemWr(memwr),
        .MemToReg(memtoreg), .ALUcntrl(aluc),
        .seOut(seOut0), .reg_Da(reg_Da0), .Zero(Zero0), .wb_valid(wb_valid0),
        .wb_addr(wb_addr0), .wb_data(wb_data0), .retired(retired0)
    );

    pipelined_datapath #(.WIDTH(16), .NREG(8), .DMEM_DEPTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .Instructions(instr),
        .RegDst(regdst), .RegWr(regwr), .ALUsrc(alusrc), .MemWr(memwr),
        .MemToReg(memtoreg), .ALUcntrl(aluc),
        .seOut(seOut1), .reg_Da(reg_Da1), .Zero(Zero1), .wb_valid(wb_valid1),
        .wb_addr(wb_addr1), .wb_data(wb_data1), .retired(retired1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ------------------------------------------------------------------
    // Sequential reference model: index 0 = WIDTH 32 / NREG 32 / depth 64,
    // index 1 = WIDTH 16 / NREG 8 / depth 16.
    // ------------------------------------------------------------------
    logic [31:0] m_regs [2][32];
    logic [31:0] m_mem  [2][64];

    typedef struct packed {
        logic        zero0;
        logic        wbv0;
        logic [4:0]  addr;
        logic [31:0] data0;
        logic        zero1;
        logic        wbv1;
        logic [15:0] data1;
        logic        st;
        logic [5:0]  idx0;
        logic [5:0]  idx1;
        logic [31:0] old0;
        logic [31:0] old1;
    } exp_t;

    exp_t exp_q[$];

    logic        tb_ex_v;
    logic        tb_mem_v;
    logic [31:0] tb_retired;

    task automatic model_exec(input int s, input logic [31:0] ins,
                              input logic rdst, input logic rw, input logic as_,
                              input logic mw, input logic mr, input logic [1:0] op,
                              output logic zero, output logic wbv,
                              output logic [31:0] data, output logic [5:0] idx,
                              output logic [31:0] old);
        logic [31:0] mask, a, bt, se, b, alu;
        logic [4:0]  rs, rt, rd, dest;
        int          nreg, depth;
        mask  = (s == 1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        nreg  = (s == 1) ? 8 : 32;
        depth = (s == 1) ? 16 : 64;
        rs = ins[25:21];
        rt = ins[20:16];
        rd = ins[15:11];
        a  = (rs == 5'd0 || int'(rs) >= nreg) ? 32'd0 : m_regs[s][rs];
        bt = (rt == 5'd0 || int'(rt) >= nreg) ? 32'd0 : m_regs[s][rt];
        se = {{16{ins[15]}}, ins[15:0]} & mask;
        b  = as_ ? se : bt;
        case (op)
            2'b00:   alu = (a + b) & mask;
            2'b01:   alu = (a - b) & mask;
            2'b10:   alu = a & b;
            default: alu = a | b;
        endcase
        dest = rdst ? rd : rt;
        idx  = 6'((alu >> 2) & 32'(depth - 1));
        data = mr ? m_mem[s][idx] : alu;
        zero = (alu == 32'd0);
        wbv  = rw && (dest != 5'd0) && (int'(dest) < nreg);
        old  = m_mem[s][idx];
        if (mw) m_mem[s][idx] = bt;
        if (wbv) m_regs[s][dest] = data;
    endtask

    // ------------------------------------------------------------------
    // Driver: one edge of stimulus, then scoreboard compare at negedge
    // ------------------------------------------------------------------
    exp_t        st_e;
    logic        st_z0, st_v0, st_z1, st_v1;
    logic [31:0] st_d0, st_d1, st_o0, st_o1;
    logic [5:0]  st_i0, st_i1;

    task step(input logic v, input logic [31:0] ins, input logic rdst, input logic rw,
              input logic as_, input logic mw, input logic mr, input logic [1:0] op);
        in_valid = v;
        instr    = ins;
        regdst   = rdst;
        regwr    = rw;
        alusrc   = as_;
        memwr    = mw;
        memtoreg = mr;
        aluc     = op;
        @(posedge clk);
        if (!rst_n) begin
            // Everything in flight is discarded: undo its stores in reverse.
            for (int i = exp_q.size() - 1; i >= 0; i--) begin
                if (exp_q[i].st) begin
                    m_mem[0][exp_q[i].idx0] = exp_q[i].old0;
                    m_mem[1][exp_q[i].idx1] = exp_q[i].old1;
                end
            end
            exp_q.delete();
            for (int r = 0; r < 32; r++) begin
                m_regs[0][r] = 32'd0;
                m_regs[1][r] = 32'd0;
            end
            tb_ex_v    = 1'b0;
            tb_mem_v   = 1'b0;
            tb_retired = 32'd0;
        end else begin
            if (tb_mem_v) begin
                tb_retired = tb_retired + 32'd1;
                if (exp_q.size() > 0) st_e = exp_q.pop_front();
            end
            tb_mem_v = tb_ex_v;
            tb_ex_v  = v;
            if (v) begin
                model_exec(0, ins, rdst, rw, as_, mw, mr, op, st_z0, st_v0, st_d0, st_i0, st_o0);
                model_exec(1, ins, rdst, rw, as_, mw, mr, op, st_z1, st_v1, st_d1, st_i1, st_o1);
                st_e.zero0 = st_z0;
                st_e.wbv0  = st_v0;
                st_e.addr  = rdst ? ins[15:11] : ins[20:16];
                st_e.data0 = st_d0;
                st_e.zero1 = st_z1;
                st_e.wbv1  = st_v1;
                st_e.data1 = st_d1[15:0];
                st_e.st    = mw;
                st_e.idx0  = st_i0;
                st_e.idx1  = st_i1;
                st_e.old0  = st_o0;
                st_e.old1  = st_o1;
                exp_q.push_back(st_e);
            end
        end
        @(negedge clk);
        if (tb_mem_v) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_empty got=0 entries required=1");
            end else begin
                st_e = exp_q[0];
                if ({wb_valid0, wb_addr0, wb_data0, Zero0} !== {st_e.wbv0, st_e.addr, st_e.data0, st_e.zero0}) begin
                    n_fail++;
                    $display("FAIL wb32 t=%0t got v=%b a=%0d d=%h z=%b exp v=%b a=%0d d=%h z=%b", $time,
                             wb_valid0, wb_addr0, wb_data0, Zero0, st_e.wbv0, st_e.addr, st_e.data0, st_e.zero0);
                end
                n_checks++;
                if ({wb_valid1, wb_addr1, wb_data1, Zero1} !== {st_e.wbv1, st_e.addr, st_e.data1, st_e.zero1}) begin
                    n_fail++;
                    $display("FAIL wb16 t=%0t got v=%b a=%0d d=%h z=%b exp v=%b a=%0d d=%h z=%b", $time,
                             wb_valid1, wb_addr1, wb_data1, Zero1, st_e.wbv1, st_e.addr, st_e.data1, st_e.zero1);
                end
            end
        end else begin
            n_checks++;
            if ({wb_valid0, Zero0, wb_valid1, Zero1} !== 4'b0000) begin
                n_fail++;
                $display("FAIL idle_mem t=%0t got v0=%b z0=%b v1=%b z1=%b exp all 0", $time,
                         wb_valid0, Zero0, wb_valid1, Zero1);
            end
        end
        n_checks++;
        if (retired0 !== tb_retired || retired1 !== tb_retired) begin
            n_fail++;
            $display("FAIL retired t=%0t got %0d/%0d exp %0d", $time, retired0, retired1, tb_retired);
        end
    endtask

    function automatic logic [31:0] i_type(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {6'd8, rs, rt, imm};
    endfunction

    function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {6'd0, rs, rt, rd, 11'd0};
    endfunction

    task op_addi(input logic [4:0] rt, input logic [4:0] rs, input logic [15:0] imm);
        step(1'b1, i_type(rs, rt, imm), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
    endtask

    task op_r(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] op);
        step(1'b1, r_type(rs, rt, rd), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, op);
    endtask

    task op_sw(input logic [4:0] rt, input logic [4:0] rs, input logic [15:0] imm);
        step(1'b1, i_type(rs, rt, imm), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
    endtask

    task op_lw(input logic [4:0] rt, input logic [4:0] rs, input logic [15:0] imm);
        step(1'b1, i_type(rs, rt, imm), 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00);
    endtask

    // Bubble with random, ignored instruction and control
    task bubble();
        step(1'b0, $urandom(), 1'($urandom()), 1'($urandom()), 1'($urandom()),
             1'($urandom()), 1'($urandom()), 2'($urandom()));
    endtask

    task drain();
        bubble();
        bubble();
    endtask

    // Present Rs = r with in_valid low so reg_Da shows the register value.
    task show_reg(input logic [4:0] r);
        in_valid = 1'b0;
        instr    = r_type(r, 5'd0, 5'd0);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task test_reset();
        rst_n = 1'b0;
        bubble();
        step(1'b1, i_type(5'd0, 5'd1, 16'd7), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
        n_checks++;
        if ({wb_addr0, wb_data0, wb_addr1, wb_data1} !== '0) begin
            n_fail++;
            $display("FAIL reset_wb got a0=%0d d0=%h a1=%0d d1=%h exp 0", wb_addr0, wb_data0, wb_addr1, wb_data1);
        end
        rst_n = 1'b1;
        bubble();
        bubble();
        show_reg(5'd1);
        n_checks++;
        if (reg_Da0 !== 32'd0 || reg_Da1 !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_no_issue got %h/%h exp 0", reg_Da0, reg_Da1);
        end
    endtask

    task test_back_to_back();
        op_addi(5'd1, 5'd0, 16'd2015);
        op_addi(5'd2, 5'd0, 16'd404);
        op_r(5'd1, 5'd1, 5'd2, 2'b00);
        drain();
        show_reg(5'd1);
        n_checks++;
        if (reg_Da0 !== 32'd2419 || reg_Da1 !== 16'd2419) begin
            n_fail++;
            $display("FAIL b2b_r1 got %0d/%0d exp 2419", reg_Da0, reg_Da1);
        end
    endtask

    task test_store_load();
        op_sw(5'd2, 5'd0, 16'd0);
        op_lw(5'd3, 5'd0, 16'd0);
        op_r(5'd4, 5'd3, 5'd3, 2'b00);
        // store immediately followed by a load of the same word
        op_sw(5'd1, 5'd0, 16'd8);
        op_lw(5'd5, 5'd0, 16'd8);
        drain();
        show_reg(5'd4);
        n_checks++;
        if (reg_Da0 !== 32'd808 || reg_Da1 !== 16'd808) begin
            n_fail++;
            $display("FAIL ldfwd_r4 got %0d/%0d exp 808", reg_Da0, reg_Da1);
        end
        show_reg(5'd5);
        n_checks++;
        if (reg_Da0 !== 32'd2419 || reg_Da1 !== 16'd2419) begin
            n_fail++;
            $display("FAIL st_ld_r5 got %0d/%0d exp 2419", reg_Da0, reg_Da1);
        end
    endtask

    task test_distance();
        op_addi(5'd10, 5'd0, 16'd10);
        op_addi(5'd11, 5'd10, 16'd1);
        op_addi(5'd12, 5'd10, 16'd2);
        op_addi(5'd13, 5'd10, 16'd3);
        drain();
        show_reg(5'd13);
        n_checks++;
        if (reg_Da0 !== 32'd13) begin
            n_fail++;
            $display("FAIL dist3_r13 got %0d exp 13", reg_Da0);
        end
    endtask

    task test_zero_sub();
        op_r(5'd5, 5'd1, 5'd1, 2'b01);
        op_r(5'd5, 5'd1, 5'd2, 2'b01);
        op_r(5'd6, 5'd1, 5'd2, 2'b10);
        op_r(5'd6, 5'd1, 5'd2, 2'b11);
        drain();
        show_reg(5'd5);
        n_checks++;
        if (reg_Da0 !== 32'd2015) begin
            n_fail++;
            $display("FAIL sub_r5 got %0d exp 2015", reg_Da0);
        end
    endtask

    task test_sign_width();
        op_addi(5'd6, 5'd0, 16'hFFFF);
        op_addi(5'd7, 5'd0, 16'h8001);
        op_addi(5'd7, 5'd7, 16'h7FFF);
        drain();
        show_reg(5'd6);
        n_checks++;
        if (reg_Da0 !== 32'hFFFF_FFFF || reg_Da1 !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL sext_r6 got %h/%h exp ffffffff/ffff", reg_Da0, reg_Da1);
        end
        show_reg(5'd7);
        n_checks++;
        if (reg_Da0 !== 32'd0 || reg_Da1 !== 16'd0) begin
            n_fail++;
            $display("FAIL wrap_r7 got %h/%h exp 0", reg_Da0, reg_Da1);
        end
        instr = i_type(5'd0, 5'd0, 16'h1234);
        #1;
        n_checks++;
        if (seOut0 !== 32'h0000_1234 || seOut1 !== 16'h1234) begin
            n_fail++;
            $display("FAIL seout_pos got %h/%h exp 00001234/1234", seOut0, seOut1);
        end
    endtask

    task test_reg0_range();
        op_addi(5'd0, 5'd0, 16'd5);
        op_addi(5'd9, 5'd0, 16'd7);
        op_r(5'd15, 5'd9, 5'd9, 2'b00);
        op_sw(5'd13, 5'd0, 16'd256);
        op_lw(5'd3, 5'd0, 16'd0);
        drain();
        show_reg(5'd0);
        n_checks++;
        if (reg_Da0 !== 32'd0 || reg_Da1 !== 16'd0) begin
            n_fail++;
            $display("FAIL r0 got %0d/%0d exp 0", reg_Da0, reg_Da1);
        end
        show_reg(5'd9);
        n_checks++;
        if (reg_Da0 !== 32'd7 || reg_Da1 !== 16'd0) begin
            n_fail++;
            $display("FAIL r9 got %0d/%0d exp 7/0", reg_Da0, reg_Da1);
        end
        show_reg(5'd3);
        n_checks++;
        if (reg_Da0 !== 32'd13) begin
            n_fail++;
            $display("FAIL alias_r3 got %0d exp 13", reg_Da0);
        end
    endtask

    task test_reset_midflight();
        op_addi(5'd1, 5'd0, 16'd99);
        op_sw(5'd6, 5'd0, 16'd0);
        rst_n = 1'b0;
        op_addi(5'd2, 5'd0, 16'd55);
        rst_n = 1'b1;
        n_checks++;
        if ({wb_addr0, wb_data0, wb_addr1, wb_data1} !== '0) begin
            n_fail++;
            $display("FAIL midrst_wb got a0=%0d d0=%h a1=%0d d1=%h exp 0", wb_addr0, wb_data0, wb_addr1, wb_data1);
        end
        for (int r = 0; r < 32; r++) begin
            show_reg(5'(r));
            n_checks++;
            if (reg_Da0 !== 32'd0 || reg_Da1 !== 16'd0) begin
                n_fail++;
                $display("FAIL midrst_reg r=%0d got %h/%h exp 0", r, reg_Da0, reg_Da1);
            end
        end
        op_lw(5'd3, 5'd0, 16'd0);
        drain();
        show_reg(5'd3);
        n_checks++;
        if (reg_Da0 !== 32'd13) begin
            n_fail++;
            $display("FAIL midrst_mem got %h exp 13", reg_Da0);
        end
    endtask

    task test_bubbles();
        int          pulses0, pulses1;
        logic [31:0] base;
        pulses0 = 0;
        pulses1 = 0;
        base    = retired0;
        for (int i = 0; i < 8; i++) begin
            if (i < 6 && (i % 2) == 0) op_addi(5'(1 + i / 2), 5'd0, 16'($urandom_range(1, 1000)));
            else bubble();
            pulses0 += int'(wb_valid0);
            pulses1 += int'(wb_valid1);
        end
        n_checks++;
        if (retired0 - base !== 32'd3) begin
            n_fail++;
            $display("FAIL bubble_retired got %0d exp 3", retired0 - base);
        end
        n_checks++;
        if (pulses0 != 3 || pulses1 != 3) begin
            n_fail++;
            $display("FAIL bubble_pulses got %0d/%0d exp 3", pulses0, pulses1);
        end
    endtask

    task test_random();
        for (int i = 0; i < 8; i++) op_sw(5'(i), 5'd0, 16'(4 * i));
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 5))
                0:       bubble();
                1:       op_addi(5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)), 16'($urandom()));
                2:       op_r(5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
                              5'($urandom_range(0, 15)), 2'($urandom()));
                3:       op_sw(5'($urandom_range(0, 15)), 5'd0, 16'(4 * $urandom_range(0, 7)));
                4:       op_lw(5'($urandom_range(1, 15)), 5'd0, 16'(4 * $urandom_range(0, 7)));
                default: op_r(5'($urandom_range(1, 15)), 5'($urandom_range(0, 15)),
                              5'($urandom_range(0, 15)), 2'b01);
            endcase
        end
        drain();
    endtask

    // ------------------------------------------------------------------
    // Sequence and report
    // ------------------------------------------------------------------
    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        instr      = '0;
        regdst     = 1'b0;
        regwr      = 1'b0;
        alusrc     = 1'b0;
        memwr      = 1'b0;
        memtoreg   = 1'b0;
        aluc       = 2'b00;
        tb_ex_v    = 1'b0;
        tb_mem_v   = 1'b0;
        tb_retired = 32'd0;
        for (int r = 0; r < 32; r++) begin
            m_regs[0][r] = 32'd0;
            m_regs[1][r] = 32'd0;
        end
        for (int a = 0; a < 64; a++) begin
            m_mem[0][a] = 32'd0;
            m_mem[1][a] = 32'd0;
        end
        @(negedge clk);
        test_reset();
        test_back_to_back();
        test_store_load();
        test_distance();
        test_zero_sub();
        test_sign_width();
        test_reg0_range();
        test_reset_midflight();
        test_bubbles();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish exp finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
